// File: rtl/stream_demux_n.sv
// stream_demux_n: 1-to-N valid/ready stream demultiplexer with a registered output stage,
// optional packet-locked routing and per-channel delivered-packet / dropped-beat counters.
module stream_demux_n #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int LOCK  = 1,
  parameter int CNTW  = 16,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    s_data,
  input  logic [SELW-1:0]     s_sel,
  input  logic                s_last,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [N*WIDTH-1:0]  m_data,
  output logic [N-1:0]        m_valid,
  output logic                m_last,
  input  logic [N-1:0]        m_ready,
  output logic [N*CNTW-1:0]   pkt_cnt,
  output logic [CNTW-1:0]     drop_cnt
);

  typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_e;

  localparam logic [SELW:0] NUM_CH = (SELW + 1)'(N);

  state_e            state_q, state_d;
  logic [SELW-1:0]   lock_ch_q, lock_ch_d;
  logic [SELW-1:0]   ch_q, ch_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;
  logic [CNTW-1:0]   pkt_cnt_q [N];
  logic [CNTW-1:0]   pkt_cnt_d [N];
  logic [CNTW-1:0]   drop_cnt_q, drop_cnt_d;

  logic [SELW-1:0]   dest;
  logic              dest_bad;
  logic              held_ready;
  logic              accept;
  logic              deliver;
  logic              discard;

  // Only the ready of the lane currently holding a beat matters.
  always_comb begin
    held_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (ch_q == SELW'(k)) held_ready = m_ready[k];
    end
  end

  assign s_ready  = !rst && (state_q == DROP || !valid_q || held_ready);
  assign dest     = (LOCK != 0 && state_q == ROUTE) ? lock_ch_q : s_sel;
  assign dest_bad = {1'b0, dest} >= NUM_CH;
  assign accept   = s_valid && s_ready;
  assign deliver  = valid_q && held_ready;
  assign discard  = accept && (state_q == DROP || dest_bad);

  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    if (LOCK != 0 && accept) begin
      case (state_q)
        IDLE: begin
          if (!s_last) begin
            if (dest_bad) begin
              state_d = DROP;
            end else begin
              state_d   = ROUTE;
              lock_ch_d = dest;
            end
          end
        end
        ROUTE, DROP: begin
          if (s_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A delivery and a new load in the same cycle leave the register full with no bubble.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    last_d  = last_q;
    if (deliver) valid_d = 1'b0;
    if (accept && !discard) begin
      valid_d = 1'b1;
      data_d  = s_data;
      ch_d    = dest;
      last_d  = s_last;
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (discard && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNTW'(1);
    for (int k = 0; k < N; k++) begin
      pkt_cnt_d[k] = pkt_cnt_q[k];
      if (deliver && last_q && ch_q == SELW'(k)) pkt_cnt_d[k] = pkt_cnt_q[k] + CNTW'(1);
    end
  end

  always_comb begin
    m_valid = '0;
    m_data  = '0;
    pkt_cnt = '0;
    for (int k = 0; k < N; k++) begin
      if (ch_q == SELW'(k)) begin
        m_valid[k]                 = valid_q;
        m_data[k*WIDTH +: WIDTH]   = data_q;
      end
      pkt_cnt[k*CNTW +: CNTW] = pkt_cnt_q[k];
    end
  end

  assign m_last   = last_q;
  assign drop_cnt = drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_ch_q  <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      ch_q       <= '0;
      last_q     <= 1'b0;
      drop_cnt_q <= '0;
      for (int k = 0; k < N; k++) pkt_cnt_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      lock_ch_q  <= lock_ch_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      ch_q       <= ch_d;
      last_q     <= last_d;
      drop_cnt_q <= drop_cnt_d;
      for (int k = 0; k < N; k++) pkt_cnt_q[k] <= pkt_cnt_d[k];
    end
  end

endmodule

// File: tb/tb_stream_demux_n.sv
// Bench for stream_demux_n: three instances (N=4 packet mode, N=4 beat mode, N=3 packet mode)
// checked every cycle against a packet-level model, plus directed literal expectations.
module tb_stream_demux_n;

  localparam int W  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W-1:0] s_data;
  logic [1:0]   s_sel;
  logic         s_last, s_valid;
  logic [3:0]   m_ready;

  logic [W-1:0] s3_data;
  logic [1:0]   s3_sel;
  logic         s3_last, s3_valid;
  logic [2:0]   m3_ready;

  logic           a_s_ready, b_s_ready, c_s_ready;
  logic [4*W-1:0] a_m_data, b_m_data;
  logic [3*W-1:0] c_m_data;
  logic [3:0]     a_m_valid, b_m_valid;
  logic [2:0]     c_m_valid;
  logic           a_m_last, b_m_last, c_m_last;
  logic [4*CW-1:0] a_pkt, b_pkt;
  logic [3*CW-1:0] c_pkt;
  logic [CW-1:0]  a_drop, b_drop, c_drop;

  stream_demux_n #(.WIDTH(W), .N(4), .LOCK(1), .CNTW(CW)) dut_a (
    .clk(clk), .rst(rst), .s_data(s_data), .s_sel(s_sel), .s_last(s_last),
    .s_valid(s_valid), .s_ready(a_s_ready), .m_data(a_m_data), .m_valid(a_m_valid),
    .m_last(a_m_last), .m_ready(m_ready), .pkt_cnt(a_pkt), .drop_cnt(a_drop));

  stream_demux_n #(.WIDTH(W), .N(4), .LOCK(0), .CNTW(CW)) dut_b (
    .clk(clk), .rst(rst), .s_data(s_data), .s_sel(s_sel), .s_last(s_last),
    .s_valid(s_valid), .s_ready(b_s_ready), .m_data(b_m_data), .m_valid(b_m_valid),
    .m_last(b_m_last), .m_ready(m_ready), .pkt_cnt(b_pkt), .drop_cnt(b_drop));

  stream_demux_n #(.WIDTH(W), .N(3), .LOCK(1), .CNTW(CW)) dut_c (
    .clk(clk), .rst(rst), .s_data(s3_data), .s_sel(s3_sel), .s_last(s3_last),
    .s_valid(s3_valid), .s_ready(c_s_ready), .m_data(c_m_data), .m_valid(c_m_valid),
    .m_last(c_m_last), .m_ready(m3_ready), .pkt_cnt(c_pkt), .drop_cnt(c_drop));

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Packet-level model: each instance tracks the held beat and, in packet mode,
  // whether a packet is open and where it goes (-1 = being discarded).
  int nch[3] = '{4, 4, 3};
  bit lk[3]  = '{1'b1, 1'b0, 1'b1};
  bit mv[3];
  int mch[3];
  int mdat[3];
  bit mlast[3];
  bit inpkt[3];
  int pdest[3];
  int pkt[3][4];
  int drp[3];

  function automatic int in_sel(int id);   return (id == 2) ? int'(s3_sel)   : int'(s_sel);   endfunction
  function automatic int in_data(int id);  return (id == 2) ? int'(s3_data)  : int'(s_data);  endfunction
  function automatic bit in_last(int id);  return (id == 2) ? s3_last  : s_last;  endfunction
  function automatic bit in_valid(int id); return (id == 2) ? s3_valid : s_valid; endfunction
  function automatic logic [3:0] in_mr(int id); return (id == 2) ? {1'b0, m3_ready} : m_ready; endfunction

  function automatic bit exp_ready(int id);
    logic [3:0] mr;
    mr = in_mr(id);
    return !rst && (!mv[id] || mr[mch[id]] || (lk[id] && inpkt[id] && pdest[id] < 0));
  endfunction

  function automatic void model_reset();
    for (int id = 0; id < 3; id++) begin
      mv[id] = 0; mch[id] = 0; mdat[id] = 0; mlast[id] = 0;
      inpkt[id] = 0; pdest[id] = 0; drp[id] = 0;
      for (int k = 0; k < 4; k++) pkt[id][k] = 0;
    end
  endfunction

  function automatic void model_step(int id);
    logic [3:0] mr;
    bit ready, take;
    int dest;
    mr    = in_mr(id);
    ready = exp_ready(id);
    take  = in_valid(id) && ready;
    if (mv[id] && mr[mch[id]]) begin
      if (mlast[id]) pkt[id][mch[id]] = (pkt[id][mch[id]] + 1) % (1 << CW);
      mv[id] = 0;
    end
    if (take) begin
      if (lk[id] && inpkt[id]) dest = pdest[id];
      else dest = (in_sel(id) >= nch[id]) ? -1 : in_sel(id);
      if (dest < 0) begin
        if (drp[id] < (1 << CW) - 1) drp[id]++;
      end else begin
        mv[id] = 1; mch[id] = dest; mdat[id] = in_data(id); mlast[id] = in_last(id);
      end
      if (lk[id]) begin
        if (in_last(id)) inpkt[id] = 0;
        else if (!inpkt[id]) begin
          inpkt[id] = 1;
          pdest[id] = dest;
        end
      end
    end
  endfunction

  function automatic logic [63:0] exp_valid(int id);
    return mv[id] ? (64'd1 << mch[id]) : 64'd0;
  endfunction

  function automatic logic [63:0] exp_data(int id);
    return 64'(mdat[id]) << (mch[id] * W);
  endfunction

  function automatic logic [63:0] exp_pkt(int id);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < nch[id]; k++) r = r | (64'(pkt[id][k]) << (k * CW));
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else for (int id = 0; id < 3; id++) model_step(id);
  end

  always @(negedge clk) begin
    checkOutput("a_s_ready", a_s_ready, exp_ready(0));
    checkOutput("a_m_valid", a_m_valid, exp_valid(0));
    checkOutput("a_m_data",  a_m_data,  exp_data(0));
    checkOutput("a_m_last",  a_m_last,  mlast[0]);
    checkOutput("a_pkt_cnt", a_pkt,     exp_pkt(0));
    checkOutput("a_drop_cnt", a_drop,   drp[0]);
    checkOutput("b_s_ready", b_s_ready, exp_ready(1));
    checkOutput("b_m_valid", b_m_valid, exp_valid(1));
    checkOutput("b_m_data",  b_m_data,  exp_data(1));
    checkOutput("b_m_last",  b_m_last,  mlast[1]);
    checkOutput("b_pkt_cnt", b_pkt,     exp_pkt(1));
    checkOutput("b_drop_cnt", b_drop,   drp[1]);
    checkOutput("c_s_ready", c_s_ready, exp_ready(2));
    checkOutput("c_m_valid", c_m_valid, exp_valid(2));
    checkOutput("c_m_data",  c_m_data,  exp_data(2));
    checkOutput("c_m_last",  c_m_last,  mlast[2]);
    checkOutput("c_pkt_cnt", c_pkt,     exp_pkt(2));
    checkOutput("c_drop_cnt", c_drop,   drp[2]);
  end

  task automatic applyStimulus(input bit v, input logic [1:0] sel, input bit last,
                               input logic [7:0] data, input logic [3:0] mr);
    s_valid = v; s_sel = sel; s_last = last; s_data = data; m_ready = mr;
    @(posedge clk); #1;
  endtask

  task automatic applyStimulusC(input bit v, input logic [1:0] sel, input bit last,
                                input logic [7:0] data, input logic [2:0] mr);
    s3_valid = v; s3_sel = sel; s3_last = last; s3_data = data; m3_ready = mr;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    s_valid = 0; s_sel = 0; s_last = 0; s_data = 0; m_ready = 4'h0;
    s3_valid = 0; s3_sel = 0; s3_last = 0; s3_data = 0; m3_ready = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_s_ready", a_s_ready, 1'b0);
    checkOutput("reset_m_valid", a_m_valid, 4'h0);
    rst = 1'b0;

    // One single-beat packet to each channel.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 2'(i), 1, 8'(8'h11 + i), 4'hf);
      checkOutput("t1_m_valid", a_m_valid, 4'b0001 << i);
      checkOutput("t1_m_data", a_m_data, 32'(8'h11 + i) << (8 * i));
    end
    applyStimulus(0, 0, 0, 8'h00, 4'hf);
    checkOutput("t1_pkt_cnt", a_pkt, 16'h1111);

    // 3-beat packet: lane 2 when locked, per-beat select otherwise.
    applyStimulus(1, 2, 0, 8'h21, 4'hf);
    checkOutput("t2_a_beat0", a_m_valid, 4'b0100);
    checkOutput("t2_b_beat0", b_m_valid, 4'b0100);
    applyStimulus(1, 0, 0, 8'h22, 4'hf);
    checkOutput("t2_a_beat1", a_m_valid, 4'b0100);
    checkOutput("t2_b_beat1", b_m_valid, 4'b0001);
    applyStimulus(1, 1, 1, 8'h23, 4'hf);
    checkOutput("t2_a_beat2", a_m_valid, 4'b0100);
    checkOutput("t2_a_data2", a_m_data, 32'h0023_0000);
    applyStimulus(1, 1, 1, 8'h31, 4'hf);
    checkOutput("t2_a_next_pkt", a_m_valid, 4'b0010);
    applyStimulus(0, 0, 0, 8'h00, 4'hf);

    // Backpressure on channel 1.
    applyStimulus(1, 1, 1, 8'hA5, 4'b1101);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 1, 8'hB6, 4'b1101);
      checkOutput("t3_s_ready_low", a_s_ready, 1'b0);
      checkOutput("t3_held_data", a_m_data, 32'h0000_A500);
    end
    applyStimulus(1, 0, 1, 8'hB6, 4'hf);
    checkOutput("t3_reload_valid", a_m_valid, 4'b0001);
    checkOutput("t3_reload_data", a_m_data, 32'h0000_00B6);
    applyStimulus(0, 0, 0, 8'h00, 4'hf);
    checkOutput("t3_pkt_cnt", a_pkt, 16'h1232);

    // N=3: packet to the nonexistent channel 3 is swallowed.
    applyStimulusC(1, 3, 0, 8'h60, 3'b111);
    checkOutput("t4_no_valid0", c_m_valid, 3'b000);
    checkOutput("t4_ready_drop", c_s_ready, 1'b1);
    applyStimulusC(1, 0, 1, 8'h61, 3'b111);
    checkOutput("t4_no_valid1", c_m_valid, 3'b000);
    checkOutput("t4_drop_cnt", c_drop, 4'd2);
    applyStimulusC(1, 0, 1, 8'h40, 3'b111);
    checkOutput("t4_route_ch0", c_m_valid, 3'b001);
    checkOutput("t4_route_data", c_m_data, 24'h00_0040);
    applyStimulusC(0, 0, 0, 8'h00, 3'b111);

    // Asynchronous reset while a packet is open and a beat is held.
    applyStimulus(1, 2, 0, 8'h51, 4'h0);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_rst_valid", a_m_valid, 4'h0);
    checkOutput("t5_rst_data", a_m_data, 32'h0);
    checkOutput("t5_rst_ready", a_s_ready, 1'b0);
    checkOutput("t5_rst_pkt", a_pkt, 16'h0);
    s_valid = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(1, 3, 1, 8'h52, 4'hf);
    checkOutput("t5_unlocked", a_m_valid, 4'b1000);
    applyStimulus(0, 0, 0, 8'h00, 4'hf);

    // Counter wrap and saturation.
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 1, 8'(i), 4'hf);
    applyStimulus(0, 0, 0, 8'h00, 4'hf);
    checkOutput("t6_pkt_wrap", a_pkt, 16'h1000);
    for (int i = 0; i < 20; i++) applyStimulusC(1, 3, 1, 8'(i), 3'b111);
    applyStimulusC(0, 0, 0, 8'h00, 3'b111);
    checkOutput("t6_drop_sat", c_drop, 4'hF);

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_demux_n.md
# stream_demux_n

Parametrised 1-to-N stream demultiplexer with valid/ready handshaking, one registered output stage, optional packet-locked routing, and per-channel statistics. It replaces the fixed, purely combinational 1:2 demux wherever a data stream must be steered to one of N consumers without losing beats under backpressure. Unselected lanes output zero, so the block can still act as a plain demux primitive when N=2 and all ready inputs are tied high.

## Interface
- WIDTH, 8: data width per beat.
- N, 4: number of output channels, 2..16.
- LOCK, 1: 1 = packet mode (select latched on first beat, held until `s_last`); 0 = beat mode (every beat routed by its own `s_sel`).
- CNTW, 16: width of each statistics counter.
- SELW (localparam): $clog2(N), minimum 1.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  WIDTH  input beat.
- s_sel  in  SELW  destination channel index.
- s_last  in  1  final beat of a packet.
- s_valid  in  1  input beat present.
- s_ready  out  1  block accepts the beat this cycle.
- m_data  out  N*WIDTH  lane k = bits [k*WIDTH +: WIDTH].
- m_valid  out  N  one-hot or zero.
- m_last  out  1  last flag of the held beat.
- m_ready  in  N  per-channel consumer ready.
- pkt_cnt  out  N*CNTW  packets delivered per channel; lane layout matches `m_data`.
- drop_cnt  out  CNTW  beats discarded because of an out-of-range select.

## Operation
- Output register holds `{data, ch, last, valid}`. `m_valid[ch]` equals `valid`. All other `m_valid` bits are 0. Lane `ch` of `m_data` carries the data; all other lanes are 0.
- Output handshake: a beat is delivered when `valid && m_ready[ch]`.
- Input handshake: a beat is accepted when `s_valid && s_ready`.
- `s_ready = !rst && (state==DROP || !valid || m_ready[ch])`. This makes it a pipeline register with a 1-beat/cycle pass-through when the consumer is ready.
- Destination `d`:
  - LOCK=0: `d = s_sel`.
  - LOCK=1, state IDLE: `d = s_sel`.
  - LOCK=1, state ROUTE: `d = lock_ch`. `s_sel` is ignored.
- State machine (LOCK=1 only; with LOCK=0 the state stays IDLE and only the DROP rule applies per beat):
  - IDLE, accepted beat, `d<N`, `!s_last` -> ROUTE. `lock_ch <= d`.
  - IDLE, accepted beat, `d>=N`, `!s_last` -> DROP.
  - IDLE, accepted beat, `s_last` -> IDLE. This covers single-beat packets, routed or dropped.
  - ROUTE, accepted beat with `s_last` -> IDLE.
  - DROP, accepted beat with `s_last` -> IDLE.
- Beat with `d>=N`, or any beat in DROP:
  - accepted and discarded; it never enters the output register;
  - `drop_cnt` increments, saturating at all-ones.
- Any other accepted beat loads the output register, with `valid=1`. The same-cycle load-and-deliver case is allowed.
- `pkt_cnt` lane `ch` increments, wrapping modulo 2^CNTW, on every delivery with `last=1`.

## Timing
- Reset, asynchronous, forces:
  - state IDLE, `lock_ch=0`;
  - output register cleared: `valid=0`, `data=0`, `ch=0`, `last=0`;
  - all counters 0.
- Consequence during reset: `m_valid=0`, `m_data=0`, `m_last=0`, `s_ready=0`, `pkt_cnt=0`, `drop_cnt=0`.
- Reset mid-packet: the held beat is lost and the lock is released. The next accepted beat after reset is treated as a packet start.
- Latency: accepted in cycle t -> `m_valid` asserted in cycle t+1.
- Backpressure:
  - a held beat stays stable (data, `ch`, `last`) until delivered;
  - while it is held and `m_ready[ch]=0`, `s_ready` is 0, except in DROP.
- `m_ready` of non-selected channels has no effect.
- Simultaneous deliver and accept:
  - the register reloads with the new beat, with no bubble;
  - `pkt_cnt` updates for the departing beat.
- Channel switch between packets (LOCK=1) or between beats (LOCK=0) costs no cycles.
- Counters are registered: visible the cycle after the triggering handshake.

## Test plan
- Reset release, `m_ready=4'b1111`, N=4, WIDTH=8: beats 0x11..0x14 with `s_sel`=0,1,2,3 and `s_last=1` -> `m_valid` = 0001, 0010, 0100, 1000 on consecutive cycles starting one cycle after each accept; non-selected lanes are 0x00; `pkt_cnt` = 1 on every lane.
- LOCK=1, 3-beat packet with `s_sel` = 2, 0, 1 per beat, `s_last` on the third -> all three beats appear on lane 2; next packet with `s_sel=1` appears on lane 1.
- Backpressure: hold `m_ready[1]=0` for 3 cycles with a beat 0xA5 routed to channel 1 -> `s_ready=0`, `m_data` lane 1 stays 0xA5; release -> delivered once, next beat accepted the same cycle.
- N=3, `s_sel=3` 2-beat packet -> `s_ready=1` both beats, no `m_valid`, `drop_cnt=2`; a following packet to channel 0 is routed normally.
- Assert `rst` asynchronously while a beat is held mid-packet -> all outputs zero immediately; after release, a beat with `s_sel=3` routes to lane 3 (lock cleared).
- CNTW=4: deliver 16 packets to channel 0 -> `pkt_cnt` lane 0 wraps to 0. Drop 20 beats -> `drop_cnt` saturates at 0xF.
